// File: rtl/ldr_adc_pkg.sv
// Shared constants and state type for the LDR ADC SPI responder.
package ldr_adc_pkg;

  localparam int FRAME_BITS      = 16;
  localparam int LEAD_ZEROS      = 4;
  localparam int ADDR_FIRST_EDGE = 3;
  localparam int ADDR_BITS       = 3;
  localparam int CNT_W           = $clog2(FRAME_BITS);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Frame layout: leading zeros followed by the sample, MSB first.
  function automatic logic [FRAME_BITS-1:0] frame_word(
    input logic [FRAME_BITS-LEAD_ZEROS-1:0] sample
  );
    return {{LEAD_ZEROS{1'b0}}, sample};
  endfunction

endpackage

// File: rtl/ldr_adc_responder_sync_edge_det.sv
// Multi-flop synchronizer with rise/fall strobes taken from the last two
// registered stages, so a strobe is one clk_sys wide and glitch-free.
module sync_edge_det #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_sys,
  input  logic rst_b,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              last;

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      chain <= {STAGES{RST_VAL}};
      last  <= RST_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      last  <= chain[STAGES-1];
    end
  end

  assign rise = chain[STAGES-1] & ~last;
  assign fall = ~chain[STAGES-1] & last;

endmodule

// File: rtl/ldr_adc_responder.sv
// SPI responder emulating the 8-channel 12-bit LDR ADC; all SPI pins are
// oversampled in the clk_clk domain.
//
// state | meaning
// IDLE  | cs_n high, dout held at 0, waiting for cs_n fall
// SHIFT | frame in progress, shifting on synced sclk edges
module ldr_adc_responder
  import ldr_adc_pkg::*;
#(
  parameter int DATA_W      = 12,
  parameter int NUM_CH      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset_n,
  input  logic                     adc_sclk,
  input  logic                     adc_cs_n,
  input  logic                     adc_din,
  output logic                     adc_dout,
  input  logic [NUM_CH*DATA_W-1:0] ch_data_i,
  output logic [ADDR_BITS-1:0]     cur_ch_o,
  output logic                     frame_done_o,
  output logic                     frame_err_o
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] ADDR_LO  = CNT_W'(ADDR_FIRST_EDGE);
  localparam logic [CNT_W-1:0] ADDR_HI  = CNT_W'(ADDR_FIRST_EDGE + ADDR_BITS - 1);

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] din_sync;
  logic                   din_s;

  state_e state, state_nxt;

  logic [CNT_W-1:0]      bit_cnt;
  logic [CNT_W-1:0]      edge_idx;
  logic [FRAME_BITS-1:0] shreg;
  logic [ADDR_BITS-1:0]  addr_next;

  logic load_first, abort, rise_ev, fall_ev, frame_end, addr_cap;

  logic [DATA_W-1:0] ch_arr [NUM_CH];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign ch_arr[k] = ch_data_i[k*DATA_W +: DATA_W];
  end

  // sclk and cs_n idle high, so their synchronizers reset high to avoid a
  // phantom fall right after reset release.
  sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk_sync (
    .clk_sys (clk_clk),
    .rst_b   (reset_reset_n),
    .d       (adc_sclk),
    .rise    (sclk_rise),
    .fall    (sclk_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk_sys (clk_clk),
    .rst_b   (reset_reset_n),
    .d       (adc_cs_n),
    .rise    (cs_rise),
    .fall    (cs_fall)
  );

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) din_sync <= '0;
    else                din_sync <= {din_sync[SYNC_STAGES-2:0], adc_din};
  end

  assign din_s = din_sync[SYNC_STAGES-1];

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state <= IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cs_fall) state_nxt = SHIFT;
      SHIFT:   if (cs_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A cs_n rise masks any sclk edge arriving in the same cycle.
  always_comb begin
    load_first = 1'b0;
    abort      = 1'b0;
    rise_ev    = 1'b0;
    fall_ev    = 1'b0;
    case (state)
      IDLE:  load_first = cs_fall;
      SHIFT: begin
        abort   = cs_rise;
        rise_ev = sclk_rise & ~cs_rise;
        fall_ev = sclk_fall & ~cs_rise;
      end
      default: ;
    endcase
  end

  assign edge_idx  = bit_cnt + CNT_W'(1);
  assign frame_end = rise_ev & (bit_cnt == LAST_CNT);
  assign addr_cap  = rise_ev & (edge_idx >= ADDR_LO) & (edge_idx <= ADDR_HI);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      adc_dout     <= 1'b0;
      cur_ch_o     <= '0;
      frame_done_o <= 1'b0;
      frame_err_o  <= 1'b0;
      bit_cnt      <= '0;
      shreg        <= '0;
      addr_next    <= '0;
    end else begin
      frame_done_o <= 1'b0;
      frame_err_o  <= 1'b0;
      if (load_first) begin
        shreg    <= frame_word(ch_arr[cur_ch_o]);
        bit_cnt  <= '0;
        adc_dout <= 1'b0;
      end else if (abort) begin
        adc_dout    <= 1'b0;
        bit_cnt     <= '0;
        frame_err_o <= (bit_cnt != '0);
      end else begin
        if (rise_ev) begin
          if (addr_cap) addr_next <= {addr_next[ADDR_BITS-2:0], din_s};
          if (frame_end) begin
            cur_ch_o     <= addr_next;
            frame_done_o <= 1'b1;
            shreg        <= frame_word(ch_arr[addr_next]);
            bit_cnt      <= '0;
          end else begin
            bit_cnt <= edge_idx;
          end
        end
        if (fall_ev) adc_dout <= shreg[LAST_CNT - bit_cnt];
      end
    end
  end

endmodule

// File: tb/tb_ldr_adc_responder.sv
// Scoreboard bench: a bit-banged SPI master pushes expected frames from a
// channel/address model; a monitor checks them on frame_done/frame_err.
module tb_ldr_adc_responder;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b1;
  logic        cs_n = 1'b1;
  logic        din = 1'b0;
  logic        dout;
  logic [95:0] ch_bus = '0;
  logic [2:0]  cur_ch;
  logic        done, err;

  always #10 clk = ~clk;

  ldr_adc_responder dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .adc_sclk      (sclk),
    .adc_cs_n      (cs_n),
    .adc_din       (din),
    .adc_dout      (dout),
    .ch_data_i     (ch_bus),
    .cur_ch_o      (cur_ch),
    .frame_done_o  (done),
    .frame_err_o   (err)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [11:0] m_ch [8];
  logic [2:0]  m_cur = '0;
  logic [15:0] exp_q [$];
  logic [15:0] rx_q [$];
  logic [2:0]  expch_q [$];
  int          err_pending = 0;
  int          rise16_cyc = 0;
  bit          din_noise = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic set_ch(input int k, input logic [11:0] v);
    m_ch[k] = v;
    ch_bus[k*12 +: 12] = v;
  endtask

  task automatic half_wait();
    repeat (HALF) @(negedge clk);
  endtask

  // addrs holds one 3-bit address per frame, frame 0 in the low bits.
  // abort_at/mutate_at/reset_at name a rise index of frame 0 (0 = unused).
  task automatic burst(input int nf, input logic [8:0] addrs, input int abort_at,
                       input int mutate_at, input int reset_at);
    logic [15:0] rx;
    logic [2:0]  a;
    @(negedge clk);
    cs_n = 1'b0;
    half_wait();
    for (int f = 0; f < nf; f++) begin
      a = addrs[f*3 +: 3];
      exp_q.push_back({4'b0, m_ch[m_cur]});
      rx = '0;
      for (int r = 1; r <= 16; r++) begin
        sclk = 1'b0;
        if (r >= 3 && r <= 5) din = a[5-r];
        else din = din_noise ? 1'($urandom) : 1'b0;
        half_wait();
        rx = {rx[14:0], dout};
        sclk = 1'b1;
        if (r == 16) begin
          rise16_cyc = cyc;
          rx_q.push_back(rx);
          expch_q.push_back(a);
          m_cur = a;
        end
        if (f == 0 && r == mutate_at) begin
          set_ch(0, 12'h000);
          for (int k = 1; k < 8; k++) set_ch(k, 12'($urandom));
        end
        half_wait();
        if (f == 0 && r == abort_at) begin
          cs_n = 1'b1;
          void'(exp_q.pop_back());
          err_pending++;
          repeat (3) @(posedge clk);
          #1;
          check("abort_dout", 32'(dout), 0);
          check("abort_err_latency", 32'(err), 1);
          half_wait();
          return;
        end
        if (f == 0 && r == reset_at) begin
          #3 rst_n = 1'b0;
          #1;
          check("rst_dout", 32'(dout), 0);
          check("rst_cur_ch", 32'(cur_ch), 0);
          check("rst_done", 32'(done), 0);
          check("rst_err", 32'(err), 0);
          void'(exp_q.pop_back());
          m_cur = '0;
          cs_n = 1'b1;
          sclk = 1'b1;
          repeat (4) @(negedge clk);
          rst_n = 1'b1;
          half_wait();
          return;
        end
      end
    end
    cs_n = 1'b1;
    din = 1'b0;
    half_wait();
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (done || err) check("done_err_exclusive", 32'(done & err), 0);
      if (done) begin
        if (exp_q.size() == 0 || rx_q.size() == 0 || expch_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got pulse expected none at cycle %0d", cyc);
        end else begin
          check("frame_data", 32'(rx_q.pop_front()), 32'(exp_q.pop_front()));
          check("cur_ch", 32'(cur_ch), 32'(expch_q.pop_front()));
          check("done_latency", 32'(cyc - rise16_cyc), 3);
        end
      end
      if (err) begin
        if (err_pending == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_err: got pulse expected none at cycle %0d", cyc);
        end else begin
          err_pending--;
          check("err_cur_ch", 32'(cur_ch), 32'(m_cur));
        end
      end
    end
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 8; k++) set_ch(k, 12'h000);
    repeat (5) @(negedge clk);
    check("reset_dout", 32'(dout), 0);
    check("reset_cur_ch", 32'(cur_ch), 0);
    check("reset_done", 32'(done), 0);
    check("reset_err", 32'(err), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // single frame, din quiet
    din_noise = 1'b0;
    set_ch(0, 12'hABC);
    burst(1, 9'd0, 0, 0, 0);
    din_noise = 1'b1;

    // addressing: first frame still ch0, second returns ch5
    set_ch(5, 12'h5A5);
    burst(1, 9'd5, 0, 0, 0);
    check("addr_cur_ch", 32'(cur_ch), 5);
    burst(1, 9'd0, 0, 0, 0);

    // continuous framing across two frames
    set_ch(2, 12'h001);
    burst(2, {3'd0, 3'd3, 3'd2}, 0, 0, 0);

    // abort mid-frame while addressing ch7
    set_ch(7, 12'h7E1);
    burst(1, 9'd7, 7, 0, 0);
    check("abort_cur_unchanged", 32'(cur_ch), 3);

    // snapshot: ch0 changes mid-frame, frame keeps 0xFFF
    burst(1, 9'd0, 0, 0, 0);
    set_ch(0, 12'hFFF);
    burst(1, 9'd0, 0, 8, 0);

    // mid-frame reset, next frame returns ch0
    burst(1, 9'd4, 0, 0, 0);
    set_ch(0, 12'h3C7);
    burst(1, 9'd6, 0, 0, 10);
    burst(1, 9'd1, 0, 0, 0);

    // randomized bursts
    repeat (25) begin
      int nf;
      int ab;
      for (int k = 0; k < 8; k++) set_ch(k, 12'($urandom));
      nf = $urandom_range(1, 3);
      ab = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 15) : 0;
      burst(nf, 9'($urandom), ab, 0, 0);
    end

    repeat (10) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    check("err_drained", 32'(err_pending), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
